// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: a DEPTH-entry FIFO whose head feeds the control decoder.
// Optional macro IR_FLUSH_EN adds a synchronous flush input that empties the queue.
module instr_prefetch_queue #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OPC_W  = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_bus,
    input  logic                   out_bus,
    input  logic                   advance,
`ifdef IR_FLUSH_EN
    input  logic                   flush,
`endif
    inout  wire  [DATA_W-1:0]      bus_data,
    output logic [OPC_W-1:0]       decoder_data,
    output logic                   head_valid,
    output logic                   full,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OPD_W = DATA_W - OPC_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic              w_flush;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [DATA_W-1:0] w_head;
    logic [DATA_W-1:0] w_drive;

`ifdef IR_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = advance && !w_empty && !w_flush;
    // A pop on the same edge frees the slot, so a push into a full queue still lands.
    assign w_push  = in_bus && (!w_full || w_pop) && !w_flush;
    assign w_drop  = in_bus && w_full && !w_pop && !w_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= bus_data;
            end
            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 1'b1;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head       = r_mem[r_rptr];
    assign w_drive      = w_empty ? '0 : {{OPC_W{1'b0}}, w_head[OPD_W-1:0]};
    assign decoder_data = w_empty ? '0 : w_head[DATA_W-1 -: OPC_W];
    assign bus_data     = out_bus ? w_drive : {DATA_W{1'bz}};

    assign head_valid = !w_empty;
    assign full       = w_full;
    assign overflow   = r_overflow;
    assign count      = r_count;

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Parametrised successor to the single-entry instruction register.
- Holds a small FIFO of fetched instruction words so fetch can run ahead of execute.
- The head entry feeds the control decoder: upper OPC_W bits form the opcode. When out_bus is asserted, the head's lower operand bits are placed onto the shared tri-state bus, zero-extended.
- Sits between the system bus and the control decoder. Fetch pushes entries; execute pops them.

Parameters:
- DATA_W, 8: instruction word and bus width.
- OPC_W, 4: opcode width, taken from the MSBs of the word. Operand width is DATA_W-OPC_W. Legal range 1..DATA_W-1.
- DEPTH, 4: number of queue entries; power of two, >=2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_bus  input  1  push: capture bus_data into tail on the clock edge.
- out_bus  input  1  drive the head's zero-extended operand onto bus_data.
- advance  input  1  pop: retire the head entry on the clock edge.
- bus_data  inout  DATA_W  shared system bus.
- decoder_data  output  OPC_W  opcode of the head entry.
- head_valid  output  1  queue non-empty.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; set when a push is dropped.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst low, asynchronous): all storage is cleared to 0.
  - Read/write pointers = 0; count = 0; overflow = 0.
  - head_valid = 0; full = 0; decoder_data = 0.
  - bus_data is released (Z) unless out_bus is asserted; an asserted out_bus drives 0.
- Reset asserted mid-operation: pending push/pop on that edge is discarded. The first push after release goes to entry 0.
- Push (in_bus=1, not full): mem[wptr] <= bus_data; wptr wraps modulo DEPTH; count+1.
- Push when full without a simultaneous pop: word dropped; overflow <= 1; contents unchanged.
- Pop (advance=1, not empty): rptr wraps modulo DEPTH; count-1.
- Pop when empty: ignored; no flag.
- Push and pop on the same edge:
  - Non-empty and non-full: both happen; count unchanged.
  - Full: both happen; the pop frees the slot and no overflow is raised.
  - Empty: the push is accepted, the pop is ignored, count becomes 1.
- Read latency: a pushed word becomes visible on decoder_data one edge after capture, when the queue was empty. No combinational bus-to-decoder bypass.
- decoder_data = mem[rptr][DATA_W-1 -: OPC_W] when non-empty, else 0.
- bus_data drive rule: when out_bus=1, drive {OPC_W zeros, mem[rptr][DATA_W-OPC_W-1:0]}. When empty and out_bus=1, drive all zeros. Otherwise Z.
- in_bus and out_bus both high: the driven value is captured (loop-back). Legal; used by bench only.
- full and head_valid are derived from count, not pointer compare.
- overflow clears only on reset.

Optional Feature:
- Macro IR_FLUSH_EN.
- When defined, adds input port flush (1 bit). flush=1 on an edge sets rptr=wptr=0 and count=0; a push or pop on the same edge is ignored. Memory contents are not cleared and overflow is retained. Used on taken jumps to discard prefetched words.
- When undefined, no flush port exists; the queue empties only via pops or reset.

Test Plan:
1. Reset, then push 0x3A with out_bus=1 on the next cycle -> decoder_data=0x3, bus_data=0x0A, count=1, head_valid=1.
2. Push 0x11,0x22,0x33,0x44 (DEPTH=4) -> full=1. Push 0x55 -> overflow=1, count=4. Pop four times -> opcodes 1,2,3,4 in order, then head_valid=0.
3. Queue full; push 0x99 and pop on the same edge -> overflow stays 0, count=4. After three more pops the head is 0x99 and decoder_data=0x9.
4. Queue empty; push 0x7C and pop together -> count=1, decoder_data=0x7. Pop with empty queue -> count stays 0.
5. Push 0xF1, 0xE2; drop rst low between edges -> count=0, decoder_data=0 immediately, without waiting for a clock edge. Release, push 0x5B -> decoder_data=0x5.
6. (IR_FLUSH_EN) Push three words, flush with advance=1 -> count=0, head_valid=0. Next push 0x6D -> decoder_data=0x6.
